fetch_align_q: RTL and testbench
================================

# fetch_align_q

Parametrised second fetch stage with an integrated instruction queue. It accepts FETCH_WIDTH-wide aligned fetch blocks from instruction memory and discards slots below the fetch PC offset or outside the slot mask. Surviving instructions are compacted in program order into a slot-granular circular queue, each tagged with a monotonically increasing age. Up to FETCH_WIDTH of the oldest instructions are presented to dispatch per cycle. Backpressure is a ready/valid handshake toward fetch_1, so an instruction memory response is never dropped when the queue is full. It sits between fetch_1 and dispatch/rename.

## Interface
Parameters:
- FETCH_WIDTH, 2, instructions per fetch block; power of two, ≥1
- DEPTH, 16, queue capacity in instructions; power of two, ≥ 2*FETCH_WIDTH
- AGE_W, 16, width of per-instruction age tag

Ports (clock and reset as in the codebase):
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  branch mispredict; clears queue and age counter
- resp_valid  in  1  fetch block present (imem response)
- resp_ready  out  1  block accepted this cycle when resp_valid && resp_ready
- resp_pc  in  32  PC of first wanted instruction; the block base is resp_pc with the low log2(FETCH_WIDTH)+2 bits cleared
- resp_data  in  FETCH_WIDTH*32  slot i in bits [32i+31:32i]
- resp_mask  in  FETCH_WIDTH  per-slot valid from fetch_1
- resp_pred  in  FETCH_WIDTH  per-slot branch prediction bit
- deq_valid  out  FETCH_WIDTH  head slots valid; thermometer-coded from bit 0
- deq_inst  out  FETCH_WIDTH*32  oldest-first instructions
- deq_pc  out  FETCH_WIDTH*32  their PCs
- deq_pred  out  FETCH_WIDTH  their prediction bits
- deq_age  out  FETCH_WIDTH*AGE_W  their age tags
- deq_count  in  clog2(FETCH_WIDTH+1)  number of head slots consumed this cycle
- occupancy  out  clog2(DEPTH+1)  current instruction count

## Operation
- Effective mask: slot i is kept iff resp_mask[i] and i ≥ word offset of resp_pc. Slot i has PC = block base + 4i.
- Kept slots are compacted in ascending slot order and written at tail, tail+1, and so on, with modulo-DEPTH wrap.
- Age: each enqueued instruction takes age_ctr + k, where k is its rank among the kept slots. age_ctr then advances by the number kept and wraps modulo 2^AGE_W.
- resp_ready = (DEPTH − occupancy ≥ FETCH_WIDTH) && !flush. It is computed from registered occupancy only, with no combinational path from deq_count.
- An accepted block with zero kept slots is consumed and nothing is written.
- Dequeue: deq_valid[j] = (j < occupancy). The outputs are the combinational read of head+j. Head advances by deq_count.
- deq_count greater than the number of valid head slots is illegal; the bench asserts against it.
- Enqueue and dequeue in the same cycle are both performed: occupancy_next = occupancy + kept − deq_count.
- Flush has priority: head, tail, occupancy and age_ctr go to 0, and any same-cycle enqueue or dequeue is discarded.
- Queue entries hold no valid bit. Validity derives only from occupancy.

## Timing
- Reset (asynchronous assert) gives: occupancy=0, head=tail=0, age_ctr=0, deq_valid=0. Once rst is low, resp_ready=1. Data outputs are don't-care while deq_valid is 0.
- Enqueue-to-dequeue latency is 1 cycle. An instruction accepted on edge N appears on deq_* after edge N, so it is first dequeuable in cycle N+1. There is no bypass from resp to deq.
- flush asserted in cycle N: queue empty and age 0 after edge N; resp_ready=0 during cycle N.
- Full boundary: resp_ready drops once fewer than FETCH_WIDTH entries are free. It rises the cycle after a dequeue restores space.
- Wrap-around: pointers are clog2(DEPTH) bits and wrap naturally. Full versus empty is distinguished by occupancy, not by pointer equality.
- Reset mid-operation clears everything asynchronously, identically to power-on.

## Test plan
- Aligned fill, FETCH_WIDTH=2. Blocks at pc 0x1000 and 0x1008, mask 11, deq_count=0 → occupancy 4; head shows pc 0x1000/0x1004, ages 0/1, deq_valid=11.
- Unaligned. resp_pc=0x100C, mask 11 → one instruction enqueued, pc 0x100C, age 0; age_ctr becomes 1.
- Full backpressure, DEPTH=4. Fill with 4 and hold resp_valid → resp_ready=0 and no overwrite. Then deq_count=2 → resp_ready=1 the next cycle, the held block is enqueued, and ages continue as 4/5.
- Simultaneous push and pop with occupancy 2: push 2, pop 2 → occupancy stays 2 and FIFO order is preserved across pointer wrap (run ≥3 full wraps).
- Flush in the same cycle as resp_valid and deq_count=2 → occupancy 0, nothing enqueued. The next accepted block has age 0.
- Asynchronous rst asserted between clock edges with occupancy 3 → deq_valid=0 immediately; occupancy 0 after release.

Source files
------------

// File: rtl/fetch_align_q.sv
// fetch_align_q: second fetch stage with an integrated instruction queue.
// Takes aligned fetch blocks from instruction memory. Drops slots that lie
// below the fetch PC offset or are masked off. Packs the survivors in program
// order into a circular queue and tags each one with a running age. Presents
// up to FETCH_WIDTH of the oldest instructions to dispatch every cycle.
module fetch_align_q #(
    parameter int FETCH_WIDTH = 2,
    parameter int DEPTH       = 16,
    parameter int AGE_W       = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                resp_valid,
    output logic                                resp_ready,
    input  logic [31:0]                         resp_pc,
    input  logic [FETCH_WIDTH*32-1:0]           resp_data,
    input  logic [FETCH_WIDTH-1:0]              resp_mask,
    input  logic [FETCH_WIDTH-1:0]              resp_pred,
    output logic [FETCH_WIDTH-1:0]              deq_valid,
    output logic [FETCH_WIDTH*32-1:0]           deq_inst,
    output logic [FETCH_WIDTH*32-1:0]           deq_pc,
    output logic [FETCH_WIDTH-1:0]              deq_pred,
    output logic [FETCH_WIDTH*AGE_W-1:0]        deq_age,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]    deq_count,
    output logic [$clog2(DEPTH+1)-1:0]          occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(FETCH_WIDTH + 1);
    // Byte offset bits inside one fetch block.
    localparam logic [31:0] BLK_OFS_MASK = 32'(FETCH_WIDTH * 4 - 1);
    // Highest occupancy at which a full block is still guaranteed to fit.
    localparam logic [OCC_W-1:0] READY_LIMIT = OCC_W'(DEPTH - FETCH_WIDTH);

    // Queue control state
    logic [PTR_W-1:0]  head_reg, head_next;
    logic [PTR_W-1:0]  tail_reg, tail_next;
    logic [OCC_W-1:0]  occ_reg, occ_next;
    logic [AGE_W-1:0]  age_ctr_reg, age_ctr_next;

    // Queue storage. No valid bits: validity comes from occupancy alone.
    logic [31:0]       mem_inst [DEPTH];
    logic [31:0]       mem_pc   [DEPTH];
    logic              mem_pred [DEPTH];
    logic [AGE_W-1:0]  mem_age  [DEPTH];

    // Incoming block decode
    logic [CNT_W-1:0]        word_off;
    logic [31:0]             block_base;
    logic [FETCH_WIDTH-1:0]  keep;
    logic [CNT_W-1:0]        slot_rank [FETCH_WIDTH];
    logic [CNT_W-1:0]        kept_cnt;
    logic [CNT_W-1:0]        enq_cnt;
    logic                    enq_fire;

    // Compacted block, position k holds the k-th kept slot
    logic [31:0]             comp_inst [FETCH_WIDTH];
    logic [31:0]             comp_pc   [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0]  comp_pred;

    // Per-position write/read addresses and enqueue ages
    logic [PTR_W-1:0]        wr_idx [FETCH_WIDTH];
    logic [AGE_W-1:0]        wr_age [FETCH_WIDTH];
    logic [PTR_W-1:0]        rd_idx [FETCH_WIDTH];

    // Acceptance depends only on registered occupancy and flush, never on
    // deq_count, so there is no combinational path from dispatch back to fetch.
    assign resp_ready = !flush && (occ_reg <= READY_LIMIT);
    assign enq_fire   = resp_valid && resp_ready;
    assign enq_cnt    = enq_fire ? kept_cnt : '0;
    assign occupancy  = occ_reg;

    // Aligned block base: PC with the in-block byte offset cleared.
    assign block_base = resp_pc & ~BLK_OFS_MASK;

    // Word offset of the first wanted instruction inside the block.
    generate
        if (FETCH_WIDTH > 1) begin : g_word_off
            assign word_off = CNT_W'(resp_pc[$clog2(FETCH_WIDTH)+1:2]);
        end else begin : g_no_word_off
            assign word_off = '0;
        end
    endgenerate

    // A slot survives when fetch_1 marked it valid and it is not before the PC.
    genvar gi;
    generate
        for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_keep
            assign keep[gi] = resp_mask[gi] && (CNT_W'(gi) >= word_off);
        end
    endgenerate

    // Rank each slot among the kept slots (prefix count) and count the survivors.
    always_comb begin
        kept_cnt = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            slot_rank[i] = kept_cnt;
            if (keep[i]) begin
                kept_cnt = kept_cnt + CNT_W'(1);
            end
        end
    end

    // Compact kept slots into consecutive positions in ascending slot order.
    always_comb begin
        comp_pred = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            comp_inst[k] = '0;
            comp_pc[k]   = '0;
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (keep[i] && (slot_rank[i] == CNT_W'(k))) begin
                    comp_inst[k] = resp_data[32*i +: 32];
                    comp_pc[k]   = block_base + 32'(4 * i);
                    comp_pred[k] = resp_pred[i];
                end
            end
        end
    end

    // Write and read addresses wrap naturally at the pointer width.
    generate
        for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_addr
            assign wr_idx[gi] = tail_reg + PTR_W'(gi);
            assign wr_age[gi] = age_ctr_reg + AGE_W'(gi);
            assign rd_idx[gi] = head_reg + PTR_W'(gi);
        end
    endgenerate

    // Head window: oldest-first combinational read, thermometer valid.
    generate
        for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_deq
            assign deq_valid[gi]                = (OCC_W'(gi) < occ_reg);
            assign deq_inst[32*gi +: 32]        = mem_inst[rd_idx[gi]];
            assign deq_pc[32*gi +: 32]          = mem_pc[rd_idx[gi]];
            assign deq_pred[gi]                 = mem_pred[rd_idx[gi]];
            assign deq_age[AGE_W*gi +: AGE_W]   = mem_age[rd_idx[gi]];
        end
    endgenerate

    // Next pointers, occupancy and age; flush overrides any enqueue/dequeue.
    always_comb begin
        head_next    = head_reg;
        tail_next    = tail_reg;
        occ_next     = occ_reg;
        age_ctr_next = age_ctr_reg;
        if (flush) begin
            head_next    = '0;
            tail_next    = '0;
            occ_next     = '0;
            age_ctr_next = '0;
        end else begin
            head_next    = head_reg + PTR_W'(deq_count);
            tail_next    = tail_reg + PTR_W'(enq_cnt);
            age_ctr_next = age_ctr_reg + AGE_W'(enq_cnt);
            occ_next     = occ_reg + OCC_W'(enq_cnt) - OCC_W'(deq_count);
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg    <= '0;
            tail_reg    <= '0;
            occ_reg     <= '0;
            age_ctr_reg <= '0;
        end else begin
            head_reg    <= head_next;
            tail_reg    <= tail_next;
            occ_reg     <= occ_next;
            age_ctr_reg <= age_ctr_next;
        end
    end

    // Queue storage write: compacted instructions land at tail, tail+1, ...
    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (enq_fire && (CNT_W'(k) < kept_cnt)) begin
                mem_inst[wr_idx[k]] <= comp_inst[k];
                mem_pc[wr_idx[k]]   <= comp_pc[k];
                mem_pred[wr_idx[k]] <= comp_pred[k];
                mem_age[wr_idx[k]]  <= wr_age[k];
            end
        end
    end

endmodule

// File: tb/tb_fetch_align_q.sv
// tb_fetch_align_q: scoreboard bench for fetch_align_q.
// The driver issues fetch blocks and dequeue counts and pushes the expected
// instructions into a reference queue; a negedge monitor compares the DUT
// head window, occupancy and ready against that queue and pops consumed ones.
module tb_fetch_align_q;

    localparam int FW    = 2;
    localparam int DEPTH = 16;
    localparam int AGE_W = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  flush = 1'b0;
    logic                  resp_valid = 1'b0;
    logic                  resp_ready;
    logic [31:0]           resp_pc = '0;
    logic [FW*32-1:0]      resp_data = '0;
    logic [FW-1:0]         resp_mask = '0;
    logic [FW-1:0]         resp_pred = '0;
    logic [FW-1:0]         deq_valid;
    logic [FW*32-1:0]      deq_inst;
    logic [FW*32-1:0]      deq_pc;
    logic [FW-1:0]         deq_pred;
    logic [FW*AGE_W-1:0]   deq_age;
    logic [1:0]            deq_count = '0;
    logic [4:0]            occupancy;

    fetch_align_q #(.FETCH_WIDTH(FW), .DEPTH(DEPTH), .AGE_W(AGE_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pc(resp_pc),
        .resp_data(resp_data), .resp_mask(resp_mask), .resp_pred(resp_pred),
        .deq_valid(deq_valid), .deq_inst(deq_inst), .deq_pc(deq_pc),
        .deq_pred(deq_pred), .deq_age(deq_age), .deq_count(deq_count),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      inst;
        logic [31:0]      pc;
        logic             pred;
        logic [AGE_W-1:0] age;
    } ent_t;

    ent_t             exp_q[$];
    logic [AGE_W-1:0] model_age = '0;
    int               total = 0;
    int               bad = 0;
    bit               mon_en = 1'b0;
    int               mon_n;
    ent_t             mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model of one accepted block: keep slots at or after the PC's
    // word, in program order, each with the next age.
    task automatic model_enq(input logic [31:0] pc, input logic [FW*32-1:0] data,
                             input logic [FW-1:0] mask, input logic [FW-1:0] pred);
        int          off;
        int          kept;
        logic [31:0] base;
        ent_t        e;
        kept = 0;
        off  = int'((pc / 32'd4) % 32'(FW));
        base = pc - (pc % 32'(FW * 4));
        for (int i = 0; i < FW; i++) begin
            if (mask[i] && i >= off) begin
                e.inst = data[32*i +: 32];
                e.pc   = base + 32'(4 * i);
                e.pred = pred[i];
                e.age  = model_age;
                model_age = model_age + 1'b1;
                exp_q.push_back(e);
                kept++;
            end
        end
        $display("enq pc=%h mask=%b kept=%0d queued=%0d", pc, mask, kept, exp_q.size());
    endtask

    // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic drive(input bit v, input logic [31:0] pc, input logic [FW*32-1:0] data,
                         input logic [FW-1:0] mask, input logic [FW-1:0] pred,
                         input int dq, input bit fl, output bit acc);
        bit rdy;
        rdy = !fl && ((DEPTH - exp_q.size()) >= FW);
        if (dq > exp_q.size()) dq = exp_q.size();
        if (dq > FW) dq = FW;
        resp_valid = v;
        resp_pc    = pc;
        resp_data  = data;
        resp_mask  = mask;
        resp_pred  = pred;
        deq_count  = 2'(dq);
        flush      = fl;
        @(posedge clk);
        #1;
        acc = v && rdy;
        if (fl) begin
            exp_q.delete();
            model_age = '0;
            $display("flush");
        end else if (acc) begin
            model_enq(pc, data, mask, pred);
        end
    endtask

    task automatic idle(input int dq);
        bit acc;
        drive(1'b0, 32'h0, '0, '0, '0, dq, 1'b0, acc);
    endtask

    task automatic do_flush();
        bit acc;
        drive(1'b0, 32'h0, '0, '0, '0, 0, 1'b1, acc);
    endtask

    function automatic logic [FW*32-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    // Monitor: compare the head window against the reference queue, then pop
    // the instructions dispatch consumes at the coming edge.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_n = exp_q.size();
            chk("occupancy", 64'(occupancy), 64'(mon_n));
            chk("resp_ready", 64'(resp_ready), 64'(!flush && ((DEPTH - mon_n) >= FW)));
            chk("deq_count_legal", 64'(int'(deq_count) <= mon_n), 64'(1));
            for (int j = 0; j < FW; j++) begin
                chk("deq_valid", 64'(deq_valid[j]), 64'(j < mon_n));
                if (j < mon_n) begin
                    chk("deq_inst", 64'(deq_inst[32*j +: 32]), 64'(exp_q[j].inst));
                    chk("deq_pc",   64'(deq_pc[32*j +: 32]),   64'(exp_q[j].pc));
                    chk("deq_pred", 64'(deq_pred[j]),          64'(exp_q[j].pred));
                    chk("deq_age",  64'(deq_age[AGE_W*j +: AGE_W]), 64'(exp_q[j].age));
                end
            end
            for (int k = 0; k < int'(deq_count); k++) begin
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    $display("deq pc=%h inst=%h pred=%0d age=%0d", mon_e.pc, mon_e.inst, mon_e.pred, mon_e.age);
                end
            end
        end
    end

    initial begin
        bit               acc;
        bit               hold;
        bit               v;
        bit               fl;
        logic [31:0]      pc;
        logic [FW*32-1:0] data;
        logic [FW-1:0]    mask;
        logic [FW-1:0]    pred;

        // Power-on reset, released between edges
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_occ", 64'(occupancy), 64'(0));
        chk("reset_deq_valid", 64'(deq_valid), 64'(0));
        chk("reset_ready", 64'(resp_ready), 64'(1));
        mon_en = 1'b1;

        // Aligned fill: two full blocks, no dequeue
        drive(1'b1, 32'h1000, rnd_data(), 2'b11, 2'b01, 0, 1'b0, acc);
        drive(1'b1, 32'h1008, rnd_data(), 2'b11, 2'b10, 0, 1'b0, acc);
        idle(0);
        chk("fill_occ", 64'(occupancy), 64'(4));

        // Unaligned: only the second slot survives
        do_flush();
        drive(1'b1, 32'h100C, rnd_data(), 2'b11, 2'b11, 0, 1'b0, acc);
        idle(0);
        chk("unaligned_pc", 64'(deq_pc[31:0]), 64'(32'h100C));
        chk("unaligned_age", 64'(deq_age[AGE_W-1:0]), 64'(0));
        // Mask hole and all-masked block
        drive(1'b1, 32'h2000, rnd_data(), 2'b10, 2'b00, 1, 1'b0, acc);
        drive(1'b1, 32'h2008, rnd_data(), 2'b00, 2'b00, 0, 1'b0, acc);
        idle(1);

        // Full backpressure: fill, hold a block, then free two slots
        do_flush();
        for (int b = 0; b < DEPTH / FW; b++) begin
            drive(1'b1, 32'h4000 + 32'(8 * b), rnd_data(), 2'b11, 2'(b), 0, 1'b0, acc);
        end
        data = rnd_data();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 32'h5000, data, 2'b11, 2'b01, 0, 1'b0, acc);
            chk("full_no_accept", 64'(acc), 64'(0));
        end
        drive(1'b1, 32'h5000, data, 2'b11, 2'b01, 2, 1'b0, acc);
        drive(1'b1, 32'h5000, data, 2'b11, 2'b01, 0, 1'b0, acc);
        chk("full_resume_accept", 64'(acc), 64'(1));
        idle(0);

        // Simultaneous push and pop across several pointer wraps
        do_flush();
        drive(1'b1, 32'h6000, rnd_data(), 2'b11, 2'b00, 0, 1'b0, acc);
        for (int c = 0; c < 30; c++) begin
            drive(1'b1, 32'h6008 + 32'(8 * c), rnd_data(), 2'b11, 2'($urandom), 2, 1'b0, acc);
        end
        chk("pushpop_occ", 64'(occupancy), 64'(2));

        // Flush with same-cycle enqueue and dequeue
        drive(1'b1, 32'h7000, rnd_data(), 2'b11, 2'b00, 2, 1'b1, acc);
        chk("flush_occ", 64'(occupancy), 64'(0));
        drive(1'b1, 32'h7100, rnd_data(), 2'b11, 2'b00, 0, 1'b0, acc);
        idle(0);
        chk("post_flush_age", 64'(deq_age[AGE_W-1:0]), 64'(0));

        // Asynchronous reset between edges with three instructions queued
        do_flush();
        drive(1'b1, 32'h8000, rnd_data(), 2'b11, 2'b00, 0, 1'b0, acc);
        drive(1'b1, 32'h800C, rnd_data(), 2'b11, 2'b00, 0, 1'b0, acc);
        idle(0);
        chk("pre_rst_occ", 64'(occupancy), 64'(3));
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_deq_valid", 64'(deq_valid), 64'(0));
        chk("async_rst_occ", 64'(occupancy), 64'(0));
        exp_q.delete();
        model_age = '0;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        chk("post_rst_occ", 64'(occupancy), 64'(0));

        // Randomized traffic; an unaccepted block is held until taken
        hold = 1'b0;
        pc   = '0;
        data = '0;
        mask = '0;
        pred = '0;
        for (int c = 0; c < 400; c++) begin
            if (!hold) begin
                pc   = $urandom & 32'hFFFF_FFFC;
                data = rnd_data();
                mask = 2'($urandom);
                pred = 2'($urandom);
                v    = ($urandom_range(0, 3) != 0);
            end
            fl = ($urandom_range(0, 49) == 0);
            drive(v, pc, data, mask, pred, $urandom_range(0, 2), fl, acc);
            hold = v && !acc && !fl;
        end
        idle(2);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
